// File: rtl/rf_sequencer_if.sv
// Load (valid/ready in) and issue (valid/ready out) handshakes of rf_sequencer.
// slave = sequencer side, master = input buffer / MAC array side.
interface rf_sequencer_if #(
   parameter int unsigned data_width = 8
);
   logic [data_width-1:0] in_data;
   logic                  in_valid;
   logic                  in_ready;
   logic                  out_valid;
   logic                  out_ready;

   modport master (
      output in_data, in_valid, out_ready,
      input  in_ready, out_valid
   );

   modport slave (
      input  in_data, in_valid, out_ready,
      output in_ready, out_valid
   );
endinterface

// File: rtl/rf_sequencer.sv
// Operand register file sequencer: loads cfg_len+1 words, then issues cfg_groups+1 four-address read groups.
// Optional RF_SEQ_STRIDE_EN: group base advances by cfg_stride instead of the fixed 4.
module rf_sequencer #(
   parameter int unsigned data_width = 8,
   parameter int unsigned depth      = 32,
   localparam int unsigned addr_width = $clog2(depth)
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   input  logic                  abort,
   input  logic [addr_width-1:0] cfg_len,
   input  logic [addr_width-1:0] cfg_groups,
   input  logic [addr_width-1:0] cfg_stride,
   rf_sequencer_if.slave         bus,
   output logic                  busy,
   output logic                  done,
   output logic                  rf_en,
   output logic                  rf_wr_ctrl,
   output logic [data_width-1:0] rf_in,
   output logic [addr_width-1:0] rf_add_in,
   output logic [addr_width-1:0] rf_add_1,
   output logic [addr_width-1:0] rf_add_2,
   output logic [addr_width-1:0] rf_add_3,
   output logic [addr_width-1:0] rf_add_4
);

   typedef enum logic [1:0] {IDLE, LOAD, READ, DONE} state_t;

   state_t                state;
   logic [addr_width-1:0] len_q;
   logic [addr_width-1:0] groups_q;
   logic [addr_width-1:0] wr_ptr;
   logic [addr_width-1:0] base;
   logic [addr_width-1:0] grp;
   logic [addr_width-1:0] step;
   logic [addr_width-1:0] next_base;
   logic                  load_act;
   logic                  accept;
   logic                  issue;

`ifdef RF_SEQ_STRIDE_EN
   logic [addr_width-1:0] stride_q;
   assign step = stride_q;
`else
   logic unused_stride;
   assign unused_stride = ^cfg_stride;
   assign step = addr_width'(4);
`endif

   // abort masks the load handshake in the same cycle so nothing is written
   assign load_act      = (state == LOAD) && !abort;
   assign accept        = load_act && bus.in_valid;
   assign issue         = (state == READ) && bus.out_ready;
   assign next_base     = base + step;

   assign bus.in_ready  = load_act;
   assign bus.out_valid = (state == READ);
   assign busy          = (state != IDLE);
   assign rf_en         = (state == LOAD);
   assign rf_wr_ctrl    = accept;
   assign rf_in         = (state == LOAD) ? bus.in_data : '0;
   assign rf_add_in     = (state == LOAD) ? wr_ptr : '0;

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= IDLE;
         len_q    <= '0;
         groups_q <= '0;
         wr_ptr   <= '0;
         base     <= '0;
         grp      <= '0;
         done     <= 1'b0;
         rf_add_1 <= '0;
         rf_add_2 <= '0;
         rf_add_3 <= '0;
         rf_add_4 <= '0;
`ifdef RF_SEQ_STRIDE_EN
         stride_q <= '0;
`endif
      end else begin
         done <= 1'b0;
         if (abort) begin
            state <= IDLE;
         end else begin
            case (state)
               IDLE: begin
                  if (start) begin
                     len_q    <= cfg_len;
                     groups_q <= cfg_groups;
`ifdef RF_SEQ_STRIDE_EN
                     stride_q <= cfg_stride;
`endif
                     wr_ptr   <= '0;
                     base     <= '0;
                     grp      <= '0;
                     state    <= LOAD;
                  end
               end
               LOAD: begin
                  if (accept) begin
                     wr_ptr <= wr_ptr + addr_width'(1);
                     if (wr_ptr == len_q) begin
                        // read addresses are registered so they hold after READ
                        rf_add_1 <= base;
                        rf_add_2 <= base + addr_width'(1);
                        rf_add_3 <= base + addr_width'(2);
                        rf_add_4 <= base + addr_width'(3);
                        state    <= READ;
                     end
                  end
               end
               READ: begin
                  if (issue) begin
                     base <= next_base;
                     grp  <= grp + addr_width'(1);
                     if (grp == groups_q) begin
                        done  <= 1'b1;
                        state <= DONE;
                     end else begin
                        rf_add_1 <= next_base;
                        rf_add_2 <= next_base + addr_width'(1);
                        rf_add_3 <= next_base + addr_width'(2);
                        rf_add_4 <= next_base + addr_width'(3);
                     end
                  end
               end
               DONE: state <= IDLE;
               default: state <= IDLE;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_rf_sequencer.sv
// Scoreboard bench for rf_sequencer: expected writes/groups queued by the driver, checked by a negedge monitor.
module tb_rf_sequencer;
   localparam int DW = 8;

   logic       clk = 1'b0;
   logic       rst, start, abort;
   logic [4:0] cfg_len, cfg_groups, cfg_stride;
   logic       busy, done, rf_en, rf_wr_ctrl;
   logic [7:0] rf_in;
   logic [4:0] rf_add_in, rf_add_1, rf_add_2, rf_add_3, rf_add_4;

   rf_sequencer_if #(.data_width(DW)) bif();

   rf_sequencer #(.data_width(DW), .depth(32)) dut (
      .clk(clk), .rst(rst), .start(start), .abort(abort),
      .cfg_len(cfg_len), .cfg_groups(cfg_groups), .cfg_stride(cfg_stride),
      .bus(bif),
      .busy(busy), .done(done), .rf_en(rf_en), .rf_wr_ctrl(rf_wr_ctrl),
      .rf_in(rf_in), .rf_add_in(rf_add_in),
      .rf_add_1(rf_add_1), .rf_add_2(rf_add_2), .rf_add_3(rf_add_3), .rf_add_4(rf_add_4)
   );

   always #5 clk = ~clk;

   typedef struct { logic [4:0] base; bit last; } grp_t;
   typedef struct { logic [4:0] addr; logic [7:0] data; } wr_t;

   int         checks = 0;
   int         failures = 0;
   grp_t       gq[$];
   wr_t        wq[$];
   logic [7:0] rf_mem    [32];
   logic [7:0] mem_model [32];
   int         ready_mode = 1;
   int         hs_count = 0;
   bit         done_due = 0, idle_due = 0, prev_stall = 0;
   logic [4:0] prev_add [4];
   logic [4:0] cur      [4];
   logic [4:0] ea;
   grp_t       g;
   wr_t        w;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic note_fail(input string name, input string detail);
      checks++;
      failures++;
      $display("FAIL %s: %s", name, detail);
   endtask

   // register file the sequencer drives
   always @(posedge clk)
      if (rf_en && rf_wr_ctrl) rf_mem[rf_add_in] <= rf_in;

   always @(posedge clk) begin
      #1;
      case (ready_mode)
         0:       bif.out_ready = 1'b0;
         1:       bif.out_ready = 1'b1;
         default: bif.out_ready = ($urandom % 100) < 60;
      endcase
   end

   always @(negedge clk) begin
      cur[0] = rf_add_1; cur[1] = rf_add_2; cur[2] = rf_add_3; cur[3] = rf_add_4;
      if (rst) begin
         done_due = 0; idle_due = 0; prev_stall = 0;
      end else begin
         if (idle_due) chk("idle_after_done", {31'd0, busy}, 32'd0);
         if (done_due) chk("done_pulse", {31'd0, done}, 32'd1);
         else if (done) note_fail("unexpected_done", "done high with no final handshake one cycle earlier");
         idle_due = done_due;
         done_due = 0;
         if (rf_en && rf_wr_ctrl) begin
            if (wq.size() == 0) note_fail("spurious_write", $sformatf("write at addr %0h", rf_add_in));
            else begin
               w = wq.pop_front();
               chk("wr_addr", {27'd0, rf_add_in}, {27'd0, w.addr});
               chk("wr_data", {24'd0, rf_in}, {24'd0, w.data});
            end
         end
         if (prev_stall)
            for (int k = 0; k < 4; k++) chk("stall_hold", {27'd0, cur[k]}, {27'd0, prev_add[k]});
         if (bif.out_valid && bif.out_ready) begin
            hs_count++;
            if (gq.size() == 0) note_fail("spurious_issue", $sformatf("issue at base %0h", rf_add_1));
            else begin
               g = gq.pop_front();
               for (int k = 0; k < 4; k++) begin
                  ea = 5'(g.base + 5'(k));
                  chk("issue_addr", {27'd0, cur[k]}, {27'd0, ea});
                  chk("issue_data", {24'd0, rf_mem[cur[k]]}, {24'd0, mem_model[ea]});
               end
               if (g.last) done_due = 1;
            end
         end
         prev_stall = bif.out_valid && !bif.out_ready;
         for (int k = 0; k < 4; k++) prev_add[k] = cur[k];
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_start(input int len, input int groups, input int stride);
      int step;
`ifdef RF_SEQ_STRIDE_EN
      step = stride;
`else
      step = 4;
`endif
      cfg_len = 5'(len); cfg_groups = 5'(groups); cfg_stride = 5'(stride);
      start = 1'b1;
      hs_count = 0;
      for (int gi = 0; gi <= groups; gi++) begin
         grp_t e;
         e.base = 5'((gi * step) % 32);
         e.last = (gi == groups);
         gq.push_back(e);
      end
      tick();
      start = 1'b0;
      chk("busy_after_start", {31'd0, busy}, 32'd1);
      chk("in_ready_after_start", {31'd0, bif.in_ready}, 32'd1);
      // scramble cfg to show it is only sampled at start
      cfg_len = 5'($urandom); cfg_groups = 5'($urandom); cfg_stride = 5'($urandom);
   endtask

   // pct < 0 alternates in_valid 1,0,1,...
   task automatic do_load(input int len, input int pct, input int abort_at, input bit seq_data);
      int i = 0;
      int cyc = 0;
      bit acc;
      bit pushed = 0;
      logic [7:0] word;
      word = seq_data ? 8'h10 : 8'($urandom);
      while (i <= len) begin
         if (i == abort_at) begin
            bif.in_valid = 1'b1; bif.in_data = word; abort = 1'b1;
            @(negedge clk);
            chk("abort_no_write", {31'd0, rf_wr_ctrl}, 32'd0);
            chk("abort_no_ready", {31'd0, bif.in_ready}, 32'd0);
            tick();
            abort = 1'b0; bif.in_valid = 1'b0;
            chk("abort_idle", {31'd0, busy}, 32'd0);
            chk("abort_no_done", {31'd0, done}, 32'd0);
            gq.delete(); wq.delete();
            return;
         end
         bif.in_valid = (pct < 0) ? (cyc % 2 == 0) : (($urandom % 100) < pct);
         bif.in_data  = word;
         if (bif.in_valid && !pushed) begin
            wr_t e;
            e.addr = 5'(i); e.data = word;
            wq.push_back(e);
            pushed = 1;
         end
         @(negedge clk);
         acc = bif.in_valid && bif.in_ready;
         tick();
         if (acc) begin
            mem_model[i] = word;
            i++;
            pushed = 0;
            word = seq_data ? 8'(16 + i) : 8'($urandom);
            if (i > len) begin
               bif.in_valid = 1'b0;
               chk("in_ready_drop", {31'd0, bif.in_ready}, 32'd0);
               chk("out_valid_after_load", {31'd0, bif.out_valid}, 32'd1);
            end
         end
         cyc++;
         if (cyc > 2000) begin
            note_fail("load_timeout", $sformatf("only %0d of %0d words accepted", i, len + 1));
            bif.in_valid = 1'b0;
            return;
         end
      end
   endtask

   task automatic wait_idle();
      int cyc = 0;
      while (busy && cyc < 500) begin
         tick();
         cyc++;
      end
      if (busy) note_fail("pass_timeout", "busy still high after 500 cycles");
      chk("groups_left", gq.size(), 32'd0);
      chk("writes_left", wq.size(), 32'd0);
   endtask

   task automatic run_pass(input int len, input int groups, input int stride, input int pct, input int mode);
      ready_mode = mode;
      do_start(len, groups, stride);
      do_load(len, pct, -1, 1'b0);
      wait_idle();
   endtask

   task automatic check_zero_state(input string name);
      chk({name, "_busy"}, {31'd0, busy}, 32'd0);
      chk({name, "_done"}, {31'd0, done}, 32'd0);
      chk({name, "_out_valid"}, {31'd0, bif.out_valid}, 32'd0);
      chk({name, "_in_ready"}, {31'd0, bif.in_ready}, 32'd0);
      chk({name, "_rf_ctl"}, {30'd0, rf_en, rf_wr_ctrl}, 32'd0);
      chk({name, "_rf_in"}, {24'd0, rf_in}, 32'd0);
      chk({name, "_rf_add_in"}, {27'd0, rf_add_in}, 32'd0);
      chk({name, "_rf_add"}, {12'd0, rf_add_1, rf_add_2, rf_add_3, rf_add_4}, 32'd0);
   endtask

   initial begin
      int cyc;
      rst = 1'b1; start = 1'b0; abort = 1'b0;
      cfg_len = '0; cfg_groups = '0; cfg_stride = '0;
      bif.in_valid = 1'b0; bif.in_data = 8'hA5; bif.out_ready = 1'b0;
      for (int a = 0; a < 32; a++) begin
         rf_mem[a] = '0;
         mem_model[a] = '0;
      end
      tick(); tick();
      check_zero_state("reset");
      rst = 1'b0;
      tick();

      // minimum pass: 1 word, 1 group, no stalls
      run_pass(0, 0, 4, 100, 1);

      // full load with sequential data, then backdoor readback
      ready_mode = 1;
      do_start(31, 3, 4);
      do_load(31, 100, -1, 1'b1);
      wait_idle();
      for (int a = 0; a < 32; a++) chk("backdoor", {24'd0, rf_mem[a]}, 32'(16 + a));

      // load with in_valid toggling, then issue stalled for 3 cycles
      ready_mode = 0;
      do_start(3, 1, 4);
      do_load(3, -1, -1, 1'b0);
      for (int s = 0; s < 3; s++) begin
         chk("stall_valid", {31'd0, bif.out_valid}, 32'd1);
         chk("stall_addrs", {12'd0, rf_add_1, rf_add_2, rf_add_3, rf_add_4},
             {12'd0, 5'd0, 5'd1, 5'd2, 5'd3});
         tick();
      end
      ready_mode = 1;
      wait_idle();

      // wrap-around over nine groups
      run_pass(7, 8, 4, 80, 2);

      // abort after 5 words, new start the following cycle
      ready_mode = 1;
      do_start(10, 2, 4);
      do_load(10, 100, 5, 1'b0);
      run_pass(4, 2, 4, 100, 1);

      // reset in the middle of READ once three groups have issued
      ready_mode = 2;
      do_start(5, 10, 4);
      do_load(5, 100, -1, 1'b0);
      cyc = 0;
      while (hs_count < 3 && cyc < 300) begin
         tick();
         cyc++;
      end
      if (hs_count < 3) note_fail("read_timeout", "three groups never issued");
      rst = 1'b1;
      tick();
      check_zero_state("mid_read_reset");
      rst = 1'b0;
      gq.delete(); wq.delete();
      tick();

      // stride cases (fixed step of 4 unless RF_SEQ_STRIDE_EN)
      run_pass(5, 2, 1, 100, 1);
      run_pass(5, 2, 0, 100, 1);

      for (int p = 0; p < 10; p++)
         run_pass(int'($urandom % 32), int'($urandom % 32), int'($urandom % 32),
                  30 + int'($urandom % 71), 2);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/rf_sequencer.md
# rf_sequencer

Controller that sequences the 32-entry operand register file for one convolution pass. It streams cfg_len+1 words into the register file through a valid/ready load port, then issues cfg_groups+1 four-address read groups to the MAC array through a valid/ready issue port. It drives the register file's enable, write-control, write-address, write-data and four read-address buses. It sits between the input buffer / weight loader and the register file. The MAC array samples the register file's four outputs whenever an issue handshake completes.

## Interface
- data_width, 8, word width of the register file
- depth, 32, register file entries (power of two); addr_width = log2(depth) = 5
- clk  in  1  rising-edge clock
- rst  in  1  reset, synchronous, active-high
- start  in  1  begin a pass; sampled only in IDLE
- abort  in  1  synchronous abort, returns to IDLE
- cfg_len  in  5  words to load minus 1 (0..31 → 1..32 words)
- cfg_groups  in  5  read groups minus 1 (0..31 → 1..32 groups)
- cfg_stride  in  5  base-address increment per group (used only with RF_SEQ_STRIDE_EN)
- in_data  in  data_width  load word
- in_valid  in  1  load word valid
- in_ready  out  1  sequencer accepts load word
- out_valid  out  1  read group addresses valid
- out_ready  in  1  MAC array consumes group
- busy  out  1  state ≠ IDLE
- done  out  1  one-cycle pulse at pass end
- rf_en, rf_wr_ctrl  out  1  register file enable / write control
- rf_in  out  data_width  register file write data
- rf_add_in  out  5  write address
- rf_add_1..rf_add_4  out  5 each  read addresses

## Operation
- States: IDLE, LOAD, READ, DONE.
- IDLE: when start=1, latch cfg_len, cfg_groups and cfg_stride, clear wr_ptr and base to 0, then go to LOAD.
- LOAD:
  - in_ready=1 and rf_en=1.
  - rf_wr_ctrl = in_valid, rf_in = in_data, rf_add_in = wr_ptr (combinational pass-through).
  - Each accepted word increments wr_ptr.
  - On acceptance of the word with wr_ptr == cfg_len, go to READ.
- READ:
  - out_valid=1; rf_add_k = (base + k−1) mod 32 for k=1..4, so addresses wrap 31→0.
  - On out_valid & out_ready: base += step (mod 32) and grp++.
  - On the handshake with grp == cfg_groups, go to DONE.
- DONE: done=1 for exactly one cycle, then go to IDLE.
- Outside LOAD: rf_wr_ctrl=0, rf_en=0, in_ready=0.
- Outside READ: out_valid=0, and rf_add_1..4 hold their last values.
- abort=1 in any state: go to IDLE next cycle. The write suppression in that cycle is decided as follows: abort forces rf_wr_ctrl=0 and in_ready=0 combinationally, so no word is written or accepted. done is not pulsed.
- Priority: rst > abort > start.
- start while busy is ignored.
- cfg_* inputs are not re-sampled during a pass.
- in_data is never buffered; back-pressure is by in_ready only.

## Timing
- Reset (rst high at a rising edge) clears state to IDLE, wr_ptr, base, grp, done and all registered outputs to 0. This applies in any state, including mid-LOAD/READ, with no partial completion.
- start at cycle t → LOAD with in_ready=1 at t+1.
- Load throughput is 1 word/cycle; the write commits at the edge ending the handshake cycle.
- Last load word accepted at cycle u → out_valid=1 at u+1. The register file read is combinational, so data is valid in the same cycle as out_valid.
- Issue throughput is 1 group/cycle while out_ready=1. out_valid and rf_add_* are stable while out_valid & !out_ready.
- Last group handshake at cycle v → done=1 at v+1, IDLE (busy=0) at v+2. start is accepted again at v+2.
- Minimum pass (1 word, 1 group, no stalls): start at t, write at t+1, issue at t+2, done at t+3.

## Configuration
- RF_SEQ_STRIDE_EN defined: step = cfg_stride (0 allowed, which re-reads the same group).
- RF_SEQ_STRIDE_EN undefined: step fixed at 4 (non-overlapping groups); cfg_stride is ignored and its register is not synthesised.

## Test plan
- Reset mid-READ: reset asserted with grp=3 → next cycle state IDLE, busy=0, out_valid=0, done=0, all rf_* = 0.
- Full load: cfg_len=31, values 0x10+i written with in_valid held 1 → 32 consecutive writes at addresses 0..31, in_ready drops the cycle after the last write. Backdoor readback confirms the contents.
- Stalls: in_valid toggled 1,0,1 and out_ready held 0 for 3 cycles → no write on idle cycles, rf_add_1..4 stable at 0,1,2,3 throughout the stall.
- Wrap-around (stride default 4): cfg_groups=8 → 9th group addresses 0,1,2,3 after 28,29,30,31. done pulses exactly once, one cycle after the 9th handshake.
- Abort: abort during LOAD after 5 words, with in_valid=1 in the abort cycle → no write in that cycle, IDLE next cycle, no done. A new start is accepted the following cycle.
- RF_SEQ_STRIDE_EN with cfg_stride=1, cfg_groups=2 → groups {0,1,2,3}, {1,2,3,4}, {2,3,4,5}. With cfg_stride=0 → {0,1,2,3} issued three times.
